// File: rtl/xif_offload_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xif_offload_requester_pkg
// Brief    : Shared types and helpers for the X-IF offload requester.
// Revision : 1.0 - initial release
// ============================================================================
package xif_offload_requester_pkg;

    // Storage bounds for the latched request; the top slices down to its parameters.
    localparam int XIF_RS_MAX = 64;
    localparam int XIF_ID_MAX = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } req_state_e;

    typedef struct packed {
        logic [31:0]            instr;
        logic [XIF_RS_MAX-1:0]  rs1;
        logic [XIF_ID_MAX-1:0]  id;
    } issue_req_t;

    function automatic int count_width(input int max_inflight);
        return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xif_offload_requester.sv
`default_nettype none
// ============================================================================
// Module   : xif_offload_requester
// Brief    : Core-side X-IF initiator: issue handshake, commit, result tracking.
// Revision : 1.0 - initial release
// ============================================================================
module xif_offload_requester
    import xif_offload_requester_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ID_WIDTH     = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_instr_i,
    input  logic [WIDTH-1:0]    req_rs1_i,
    input  logic                flush_i,
    output logic                issue_valid_o,
    input  logic                issue_ready_i,
    output logic [31:0]         issue_instr_o,
    output logic [WIDTH-1:0]    issue_rs0_o,
    output logic                issue_rs_valid_o,
    output logic [ID_WIDTH-1:0] issue_id_o,
    input  logic                issue_accept_i,
    input  logic                issue_writeback_i,
    output logic                commit_valid_o,
    output logic [ID_WIDTH-1:0] commit_id_o,
    output logic                commit_kill_o,
    input  logic                result_valid_i,
    output logic                result_ready_o,
    input  logic [ID_WIDTH-1:0] result_id_i,
    input  logic [4:0]          result_rd_i,
    input  logic                result_we_i,
    input  logic [WIDTH-1:0]    result_data_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_waddr_o,
    output logic [WIDTH-1:0]    rf_wdata_o,
    output logic                reject_o,
    output logic                err_o,
    output logic                busy_o
);

    localparam int                  c_CNT_W   = count_width(MAX_INFLIGHT);
    localparam int                  c_NUM_ID  = 2 ** ID_WIDTH;
    localparam logic [c_CNT_W-1:0]  c_MAX_CNT = c_CNT_W'(MAX_INFLIGHT);
    localparam logic [0:0]          S_IDLE    = IDLE;
    localparam logic [0:0]          S_ISSUE   = ISSUE;

    logic [0:0]             r_state;
    issue_req_t             r_req;
    logic [ID_WIDTH-1:0]    r_next_id;
    logic                   r_kill_pend;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_NUM_ID-1:0]    r_mask;
    logic                   r_commit_valid;
    logic [ID_WIDTH-1:0]    r_commit_id;
    logic                   r_commit_kill;
    logic                   r_reject;
    logic                   r_rf_we;
    logic [4:0]             r_rf_waddr;
    logic [WIDTH-1:0]       r_rf_wdata;
    logic                   r_err;

    logic                   w_req_fire;
    logic                   w_issue_fire;
    logic                   w_kill;
    logic                   w_track;
    logic                   w_res_hit;
    logic                   w_res_miss;
    logic [c_NUM_ID-1:0]    w_set;
    logic [c_NUM_ID-1:0]    w_clr;
    logic                   w_unused_req;

    assign req_ready_o   = !rst_i && (r_state == S_IDLE) && (r_count < c_MAX_CNT)
                           && !r_mask[r_next_id];
    assign w_req_fire    = req_valid_i && req_ready_o;
    assign w_issue_fire  = (r_state == S_ISSUE) && issue_ready_i;
    assign w_kill        = r_kill_pend || flush_i;
    // Only accepted, live instructions that will write back owe us a result.
    assign w_track       = w_issue_fire && issue_accept_i && issue_writeback_i && !w_kill;
    assign w_res_hit     = result_valid_i && r_mask[result_id_i];
    assign w_res_miss    = result_valid_i && !r_mask[result_id_i];

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_track) begin
            w_set[r_req.id[ID_WIDTH-1:0]] = 1'b1;
        end
        if (w_res_hit) begin
            w_clr[result_id_i] = 1'b1;
        end
    end

    assign issue_valid_o    = (r_state == S_ISSUE);
    assign issue_rs_valid_o = (r_state == S_ISSUE);
    assign issue_instr_o    = r_req.instr;
    assign issue_rs0_o      = r_req.rs1[WIDTH-1:0];
    assign issue_id_o       = r_req.id[ID_WIDTH-1:0];
    assign commit_valid_o   = r_commit_valid;
    assign commit_id_o      = r_commit_id;
    assign commit_kill_o    = r_commit_kill;
    assign result_ready_o   = !rst_i;
    assign rf_we_o          = r_rf_we;
    assign rf_waddr_o       = r_rf_waddr;
    assign rf_wdata_o       = r_rf_wdata;
    assign reject_o         = r_reject;
    assign err_o            = r_err;
    assign busy_o           = (r_state == S_ISSUE) || (r_count != '0);
    assign w_unused_req     = ^{r_req.rs1, r_req.id};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_req          <= '0;
            r_next_id      <= '0;
            r_kill_pend    <= 1'b0;
            r_count        <= '0;
            r_mask         <= '0;
            r_commit_valid <= 1'b0;
            r_commit_id    <= '0;
            r_commit_kill  <= 1'b0;
            r_reject       <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_err          <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_req_fire) begin
                    r_req.instr <= req_instr_i;
                    r_req.rs1   <= XIF_RS_MAX'(req_rs1_i);
                    r_req.id    <= XIF_ID_MAX'(r_next_id);
                    r_kill_pend <= flush_i;
                    r_state     <= S_ISSUE;
                end
            end else begin
                if (flush_i) begin
                    r_kill_pend <= 1'b1;
                end
                if (issue_ready_i) begin
                    r_next_id <= r_next_id + 1'b1;
                    r_state   <= S_IDLE;
                end
            end

            r_commit_valid <= w_issue_fire;
            r_reject       <= w_issue_fire && !issue_accept_i;
            if (w_issue_fire) begin
                r_commit_id   <= r_req.id[ID_WIDTH-1:0];
                r_commit_kill <= w_kill || !issue_accept_i;
            end

            r_mask <= (r_mask & ~w_clr) | w_set;
            if (w_track && !w_res_hit) begin
                r_count <= r_count + 1'b1;
            end else if (w_res_hit && !w_track) begin
                r_count <= r_count - 1'b1;
            end

            // x0 is hardwired to zero, so its writes are dropped here.
            r_rf_we <= w_res_hit && result_we_i && (result_rd_i != 5'd0);
            if (w_res_hit) begin
                r_rf_waddr <= result_rd_i;
                r_rf_wdata <= result_data_i;
            end
            r_err <= w_res_miss;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_track && !w_res_hit && (r_count == c_MAX_CNT)));
            assert (!(w_res_hit && !w_track && (r_count == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xif_offload_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_xif_offload_requester
// Brief    : Self-checking bench with a mask/queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xif_offload_requester;

    localparam int W    = 32;
    localparam int IW   = 4;
    localparam int MAXI = 4;
    localparam int NID  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_ready;
    logic [31:0]    req_instr;
    logic [W-1:0]   req_rs1;
    logic           flush;
    logic           issue_valid, issue_ready;
    logic [31:0]    issue_instr;
    logic [W-1:0]   issue_rs0;
    logic           issue_rs_valid;
    logic [IW-1:0]  issue_id;
    logic           issue_accept, issue_writeback;
    logic           commit_valid;
    logic [IW-1:0]  commit_id;
    logic           commit_kill;
    logic           result_valid, result_ready;
    logic [IW-1:0]  result_id;
    logic [4:0]     result_rd;
    logic           result_we;
    logic [W-1:0]   result_data;
    logic           rf_we;
    logic [4:0]     rf_waddr;
    logic [W-1:0]   rf_wdata;
    logic           reject, err, busy;

    xif_offload_requester #(.WIDTH(W), .ID_WIDTH(IW), .MAX_INFLIGHT(MAXI)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_instr_i(req_instr), .req_rs1_i(req_rs1), .flush_i(flush),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .issue_instr_o(issue_instr), .issue_rs0_o(issue_rs0),
        .issue_rs_valid_o(issue_rs_valid), .issue_id_o(issue_id),
        .issue_accept_i(issue_accept), .issue_writeback_i(issue_writeback),
        .commit_valid_o(commit_valid), .commit_id_o(commit_id), .commit_kill_o(commit_kill),
        .result_valid_i(result_valid), .result_ready_o(result_ready),
        .result_id_i(result_id), .result_rd_i(result_rd), .result_we_i(result_we),
        .result_data_i(result_data),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .reject_o(reject), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: set of outstanding IDs and the next ID to hand out.
    bit outstanding [NID];
    int next_id;

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NID; i++) c += int'(outstanding[i]);
        return c;
    endfunction

    function automatic bit model_ready();
        return (model_cnt() < MAXI) && !outstanding[next_id];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NID; i++) outstanding[i] = 1'b0;
        next_id = 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_status();
        chk("req_ready", 64'(req_ready), 64'(model_ready()));
        chk("busy", 64'(busy), 64'(model_cnt() != 0));
    endtask

    // One full request -> issue -> commit transaction, optionally with a
    // coprocessor result landing in the issue-handshake cycle.
    task automatic issue_one(input logic [31:0] instr, input logic [31:0] rs1,
                             input bit acc, input bit wb, input bit fl, input int dly,
                             input bit exp_kill, input bit exp_rej,
                             input bit cr_en, input int cr_id, input int cr_rd,
                             input logic [31:0] cr_data);
        int id = next_id;
        bit hit;
        chk("req_ready_pre", 64'(req_ready), 64'(model_ready()));
        req_valid = 1'b1; req_instr = instr; req_rs1 = rs1;
        tick();
        req_valid = 1'b0; req_instr = $urandom; req_rs1 = $urandom;
        chk("commit_one_cycle", 64'(commit_valid), 64'd0);
        chk("issue_valid", 64'(issue_valid), 64'd1);
        chk("issue_rs_valid", 64'(issue_rs_valid), 64'd1);
        chk("req_ready_in_issue", 64'(req_ready), 64'd0);
        chk("issue_instr", 64'(issue_instr), 64'(instr));
        chk("issue_rs0", 64'(issue_rs0), 64'(rs1));
        chk("issue_id", 64'(issue_id), 64'(id));
        if (fl) flush = 1'b1;
        for (int d = 0; d < dly; d++) begin
            tick();
            flush = 1'b0;
            chk("hold_valid", 64'(issue_valid), 64'd1);
            chk("hold_instr", 64'(issue_instr), 64'(instr));
            chk("hold_rs0", 64'(issue_rs0), 64'(rs1));
            chk("hold_id", 64'(issue_id), 64'(id));
            chk("hold_no_commit", 64'(commit_valid), 64'd0);
        end
        issue_ready = 1'b1; issue_accept = acc; issue_writeback = wb;
        if (cr_en) begin
            result_valid = 1'b1; result_id = IW'(cr_id); result_rd = 5'(cr_rd);
            result_we = 1'b1; result_data = cr_data;
        end
        hit = cr_en && outstanding[cr_id];
        tick();
        issue_ready = 1'b0; issue_accept = 1'b0; issue_writeback = 1'b0;
        flush = 1'b0; result_valid = 1'b0;
        chk("commit_valid", 64'(commit_valid), 64'd1);
        chk("commit_id", 64'(commit_id), 64'(id));
        chk("commit_kill", 64'(commit_kill), 64'(exp_kill));
        chk("reject", 64'(reject), 64'(exp_rej));
        chk("rf_we_at_commit", 64'(rf_we), 64'(hit && cr_rd != 0));
        chk("err_at_commit", 64'(err), 64'(cr_en && !hit));
        if (hit && cr_rd != 0) begin
            chk("rf_waddr_at_commit", 64'(rf_waddr), 64'(cr_rd));
            chk("rf_wdata_at_commit", 64'(rf_wdata), 64'(cr_data));
        end
        if (hit) outstanding[cr_id] = 1'b0;
        if (acc && wb && !fl) outstanding[id] = 1'b1;
        next_id = (next_id + 1) % NID;
        chk_idle_status();
    endtask

    task automatic send_result(input int id, input int rd, input bit we, input logic [31:0] data);
        bit hit = outstanding[id];
        result_valid = 1'b1; result_id = IW'(id); result_rd = 5'(rd);
        result_we = we; result_data = data;
        tick();
        result_valid = 1'b0;
        chk("err", 64'(err), 64'(!hit));
        chk("rf_we", 64'(rf_we), 64'(hit && we && rd != 0));
        if (hit && we && rd != 0) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(rd));
            chk("rf_wdata", 64'(rf_wdata), 64'(data));
        end
        if (hit) outstanding[id] = 1'b0;
        chk_idle_status();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        bit          acc, wb, fl;
        int          dly;
        bit          exp_kill, exp_rej;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_100B, 32'd5,  1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_200B, 32'd7,  1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_300B, 32'd9,  1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_400B, 32'd11, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_500B, 32'd13, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[5] = '{32'hDEAD_BEEF, 32'd15, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_instr = '0; req_rs1 = '0; flush = 1'b0;
        issue_ready = 1'b0; issue_accept = 1'b0; issue_writeback = 1'b0;
        result_valid = 1'b0; result_id = '0; result_rd = '0; result_we = 1'b0; result_data = '0;
        model_clear();
        repeat (3) tick();
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_reject", 64'(reject), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result_ready", 64'(result_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_result_ready", 64'(result_ready), 64'd1);
        chk("post_rst_issue_id", 64'(issue_id), 64'd0);
        chk_idle_status();

        // Basic transaction: id 0 returns rd=3 data=0x2A.
        issue_one(vecs[0].instr, vecs[0].rs1, vecs[0].acc, vecs[0].wb, vecs[0].fl, vecs[0].dly,
                  vecs[0].exp_kill, vecs[0].exp_rej, 1'b0, 0, 0, 32'h0);
        send_result(0, 3, 1'b1, 32'h2A);

        for (int i = 1; i < 6; i++) begin
            issue_one(vecs[i].instr, vecs[i].rs1, vecs[i].acc, vecs[i].wb, vecs[i].fl,
                      vecs[i].dly, vecs[i].exp_kill, vecs[i].exp_rej, 1'b0, 0, 0, 32'h0);
        end
        send_result(1, 5, 1'b1, 32'h1111);   // tracked
        send_result(3, 6, 1'b1, 32'h3333);   // flushed: unknown
        send_result(4, 6, 1'b1, 32'h4444);   // writeback=0: unknown
        send_result(5, 6, 1'b1, 32'h5555);   // flushed in handshake cycle

        // Reset while an issue is pending.
        req_valid = 1'b1; req_instr = 32'h0000_900B; req_rs1 = 32'd1;
        tick();
        req_valid = 1'b0;
        chk("mid_rst_valid_before", 64'(issue_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid_drop", 64'(issue_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        model_clear();
        tick();
        chk_idle_status();

        // Fill all slots with ids 0..3, then drain out of order.
        for (int i = 0; i < 4; i++) begin
            issue_one(32'h0000_0A0B + 32'(i), 32'(i), 1'b1, 1'b1, 1'b0, i % 2, 1'b0, 1'b0,
                      1'b0, 0, 0, 32'h0);
        end
        chk("full_req_ready", 64'(req_ready), 64'd0);
        send_result(2, 10, 1'b1, 32'hA2);
        chk("refill_req_ready", 64'(req_ready), 64'd1);
        send_result(3, 11, 1'b1, 32'hA3);
        send_result(0, 0, 1'b1, 32'hA0);     // rd=0 suppressed
        send_result(1, 12, 1'b1, 32'hA1);

        // Result for id 4 lands in the same cycle as the commit of id 5.
        issue_one(32'h0000_0B0B, 32'd4, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
        issue_one(32'h0000_0C0B, 32'd5, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4, 7, 32'h77);
        chk("concurrent_busy", 64'(busy), 64'd1);
        send_result(5, 8, 1'b1, 32'h88);

        // Sixteen untracked issues walk next_id through the 15 -> 0 wrap.
        for (int i = 0; i < 16; i++) begin
            issue_one($urandom, $urandom, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0);
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            int r = int'($urandom_range(0, 2));
            if (r != 0 && model_ready()) begin
                bit acc = ($urandom_range(0, 9) < 8);
                bit wb  = ($urandom_range(0, 3) != 0);
                bit fl  = ($urandom_range(0, 6) == 0);
                bit cre = ($urandom_range(0, 3) == 0);
                int cid = int'($urandom_range(0, NID - 1));
                issue_one($urandom, $urandom, acc, wb, fl, int'($urandom_range(0, 2)),
                          fl || !acc, !acc, cre, cid, int'($urandom_range(1, 31)), $urandom);
            end else begin
                int q [$];
                int id;
                for (int i = 0; i < NID; i++) if (outstanding[i]) q.push_back(i);
                if (q.size() > 0 && $urandom_range(0, 4) != 0)
                    id = q[$urandom_range(0, q.size() - 1)];
                else
                    id = int'($urandom_range(0, NID - 1));
                send_result(id, int'($urandom_range(0, 31)), 1'($urandom), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
